mem_wb_skid_reg: RTL
====================

// Module: mem_wb_skid_reg
// PURPOSE
//   Parametrised MEM->WB pipeline register with valid/ready handshake, flush and
//   optional 2-entry skid buffer. Replaces the always-load stage register so that
//   WB back-pressure (e.g. a multi-cycle register-file port) stalls MEM cleanly.
//   Carries WB_EN, MEM_R_EN, Dest, ALU result and memory read data.
//   Provides the pre-selected write-back value.
// PARAMETERS
//   DATA_W  32  width of ALU result, memory data and write-back data
//   DEST_W  4   destination register index width
//   SKID    1   1: 2-entry skid buffer, in_ready registered; 0: single entry, in_ready combinational
// PORTS
//   clk           in   1       clock, rising edge
//   rst           in   1       synchronous reset, active high
//   flush         in   1       drop all held entries (sync)
//   in_valid      in   1       MEM stage presents an instruction
//   in_ready      out  1       register can accept this cycle
//   wb_en_in      in   1       write-back enable
//   mem_r_en_in   in   1       instruction is a load
//   dest_in       in   DEST_W  destination register
//   alu_res_in    in   DATA_W  ALU result / address
//   mem_data_in   in   DATA_W  data-memory read data
//   out_valid     out  1       WB entry valid
//   out_ready     in   1       WB consumes entry this cycle
//   wb_en_out     out  1       wb_en of head entry AND out_valid
//   mem_r_en_out  out  1       mem_r_en of head entry
//   dest_out      out  DEST_W  head destination
//   alu_res_out   out  DATA_W  head ALU result
//   mem_data_out  out  DATA_W  head memory data
//   wb_data_out   out  DATA_W  mem_r_en_out ? mem_data_out : alu_res_out
// BEHAVIOUR
// - Reset (rst=1 at posedge): head/skid valid=0, all payload regs=0. All outputs 0,
//   except in_ready=1.
// - Accept = in_valid & in_ready; drain = out_valid & out_ready. Both evaluated on one edge.
// - Latency 1 cycle: an accept into an empty register gives out_valid=1 on the next cycle.
// - SKID=1 states: EMPTY(head=0,skid=0), ONE(head=1,skid=0), TWO(head=1,skid=1).
//   EMPTY: accept -> ONE (load head).
//   ONE: accept&drain -> ONE (head<=in); accept&!drain -> TWO (skid<=in);
//        drain&!accept -> EMPTY.
//   TWO: drain -> ONE (head<=skid); no accept possible.
//   in_ready = !skid_valid, registered (no out_ready->in_ready comb path).
// - SKID=0: head only; in_ready = !out_valid | out_ready (comb).
//   Accept&drain on the same edge: head reloads, out_valid stays 1.
// - Ordering strictly FIFO; no entry duplicated or dropped unless flushed.
// - flush: on the next edge head/skid valid=0. Priority over a same-cycle accept, which is
//   discarded. Payload regs hold stale data; wb_en_out=0 because of out_valid gating.
// - rst dominates flush. Reset mid-stream discards all entries.
// - Payload regs load only on accept (or skid->head move); held otherwise (stall-stable).
// - Outputs stable while out_valid=1 & out_ready=0.
// - wb_data_out is pure comb from head regs; width DATA_W, no extension.
// CONFIGURATION
//   MEM_WB_STALL_CNT_EN defined: adds output stall_cnt [15:0].
//     - Increments each cycle out_valid=1 & out_ready=0.
//     - Saturates at 16'hFFFF; cleared by rst only (not flush).
//   MEM_WB_STALL_CNT_EN undefined: port and counter absent.
//     - All other behaviour identical.
// TESTING
//   1. Reset: rst=1 2 cycles -> out_valid=0, wb_en_out=0, wb_data_out=0, in_ready=1.
//   2. Stream, out_ready=1: 4 accepts (alu 0x10..0x13) -> out_valid each cycle,
//      alu_res_out 0x10..0x13 one cycle later, in order.
//   3. Skid, SKID=1: out_ready=0, accept A=0xA, B=0xB -> in_ready=0 after B, head=A held.
//      out_ready=1 -> A then B, then in_ready=1.
//   4. Load select: mem_r_en_in=1, mem_data_in=0xDEAD, alu=0x40 -> wb_data_out=0xDEAD.
//      With mem_r_en_in=0 -> 0x40.
//   5. Flush in TWO state, with same-cycle in_valid=1 -> next cycle out_valid=0,
//      wb_en_out=0, in_ready=1; flushed input never appears.
//   6. MEM_WB_STALL_CNT_EN: hold out_ready=0 for 5 cycles with a valid head -> stall_cnt=5.
//      Flush keeps it 5; rst -> 0.

Source files
------------

// File: rtl/mem_wb_skid_reg.sv
// MEM->WB pipeline register with valid/ready handshake, flush and optional 2-entry skid buffer.
// Define MEM_WB_STALL_CNT_EN to add the saturating stall_cnt output.
module mem_wb_skid_reg #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic [DEST_W-1:0] dest_in,
    input  logic [DATA_W-1:0] alu_res_in,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wb_en_out,
    output logic              mem_r_en_out,
    output logic [DEST_W-1:0] dest_out,
    output logic [DATA_W-1:0] alu_res_out,
    output logic [DATA_W-1:0] mem_data_out,
    output logic [DATA_W-1:0] wb_data_out
`ifdef MEM_WB_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t state, next_state;

    logic              head_valid, skid_valid;
    logic              accept, drain;
    logic              load_head_in, load_head_skid, load_skid;

    logic              head_wb_en, head_mem_r_en;
    logic [DEST_W-1:0] head_dest;
    logic [DATA_W-1:0] head_alu, head_mem;
    logic              skid_wb_en, skid_mem_r_en;
    logic [DEST_W-1:0] skid_dest;
    logic [DATA_W-1:0] skid_alu, skid_mem;

    assign head_valid = (state != EMPTY);
    assign skid_valid = (state == TWO);

    // With the skid buffer, in_ready comes straight from the state register.
    assign in_ready = (SKID != 0) ? !skid_valid : (!head_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign drain    = head_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state     = state;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    next_state   = ONE;
                    load_head_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    load_head_in = 1'b1;
                end else if (accept) begin
                    if (SKID != 0) begin
                        next_state = TWO;
                        load_skid  = 1'b1;
                    end
                end else if (drain) begin
                    next_state = EMPTY;
                end
            end
            TWO: begin
                if (drain) begin
                    next_state     = ONE;
                    load_head_skid = 1'b1;
                end
            end
            default: next_state = EMPTY;
        endcase
        // Flush discards everything, including a same-cycle accept; payload stays stale.
        if (flush) begin
            next_state     = EMPTY;
            load_head_in   = 1'b0;
            load_head_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_wb_en    <= 1'b0;
            head_mem_r_en <= 1'b0;
            head_dest     <= '0;
            head_alu      <= '0;
            head_mem      <= '0;
            skid_wb_en    <= 1'b0;
            skid_mem_r_en <= 1'b0;
            skid_dest     <= '0;
            skid_alu      <= '0;
            skid_mem      <= '0;
        end else begin
            if (load_head_in) begin
                head_wb_en    <= wb_en_in;
                head_mem_r_en <= mem_r_en_in;
                head_dest     <= dest_in;
                head_alu      <= alu_res_in;
                head_mem      <= mem_data_in;
            end else if (load_head_skid) begin
                head_wb_en    <= skid_wb_en;
                head_mem_r_en <= skid_mem_r_en;
                head_dest     <= skid_dest;
                head_alu      <= skid_alu;
                head_mem      <= skid_mem;
            end
            if (load_skid) begin
                skid_wb_en    <= wb_en_in;
                skid_mem_r_en <= mem_r_en_in;
                skid_dest     <= dest_in;
                skid_alu      <= alu_res_in;
                skid_mem      <= mem_data_in;
            end
        end
    end

    assign out_valid    = head_valid;
    assign wb_en_out    = head_wb_en && head_valid;
    assign mem_r_en_out = head_mem_r_en;
    assign dest_out     = head_dest;
    assign alu_res_out  = head_alu;
    assign mem_data_out = head_mem;
    assign wb_data_out  = head_mem_r_en ? head_mem : head_alu;

`ifdef MEM_WB_STALL_CNT_EN
    // Counts cycles where WB holds off a valid entry; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (head_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
